// File: rtl/tblink_rpc_pkt_arb_if.sv
// tblink_rpc_pkt_arb_if: source and output byte channels of the packet arbiter.
// master = arbiter side, slave = sources/sink side.
interface tblink_rpc_pkt_arb_if #(
  parameter int N_PORTS = 4
);
  logic [8*N_PORTS-1:0] req_dat;
  logic [N_PORTS-1:0]   req_valid;
  logic [N_PORTS-1:0]   req_ready;
  logic [7:0]           out_dat;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_PORTS-1:0]   grant;

  modport master (
    input  req_dat, req_valid, out_ready,
    output req_ready, out_dat, out_valid, grant
  );

  modport slave (
    output req_dat, req_valid, out_ready,
    input  req_ready, out_dat, out_valid, grant
  );
endinterface

// File: rtl/tblink_rpc_pkt_arb.sv
// tblink_rpc_pkt_arb: packet-atomic round-robin arbiter over 8-bit tblink streams.
// Define TBLINK_RPC_PKT_ARB_STATS_EN to add pkt_count/last_src outputs.
module tblink_rpc_pkt_arb #(
  parameter int N_PORTS = 4,
  parameter int PTR_W   = $clog2(N_PORTS)
) (
  input  logic uclock,
  input  logic reset_n,
  input  logic hreq_i,
  output logic hreq_o,
  tblink_rpc_pkt_arb_if.master bus
`ifdef TBLINK_RPC_PKT_ARB_STATS_EN
  ,
  output logic [15:0]      pkt_count,
  output logic [PTR_W-1:0] last_src
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] PAY  = 2'd3;

  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_PORTS - 1);
  localparam logic [PTR_W:0]   NP   = (PTR_W+1)'(N_PORTS);

  logic [1:0]       state;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] rr_ptr;
  logic [7:0]       count;

  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;
  logic [PTR_W:0]   scan;
  logic             sel_vld;
  logic             busy;
  logic             xfer;
  logic             done;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr;
    scan     = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      scan = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (scan >= NP) scan = scan - NP;
      if (bus.req_valid[scan[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    bus.out_dat = bus.req_dat[7:0];
    sel_vld     = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (gnt_idx == PTR_W'(k)) begin
        bus.out_dat = bus.req_dat[8*k +: 8];
        sel_vld     = bus.req_valid[k];
      end
    end
  end

  assign busy          = (state != IDLE);
  assign bus.out_valid = busy & sel_vld;
  assign xfer          = bus.out_valid & bus.out_ready;
  assign done          = (state == PAY) && xfer && (count == 8'd0);
  assign hreq_o        = hreq_i | busy;

  always_comb begin
    bus.grant     = '0;
    bus.req_ready = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      bus.grant[k]     = busy && (gnt_idx == PTR_W'(k));
      bus.req_ready[k] = bus.grant[k] & bus.out_ready;
    end
  end

  always_ff @(posedge uclock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_idx <= pick_idx;
            state   <= HDR;
          end
        end
        HDR: begin
          if (xfer) state <= CNT;
        end
        CNT: begin
          if (xfer) begin
            count <= bus.out_dat;
            state <= PAY;
          end
        end
        PAY: begin
          if (xfer) begin
            if (count == 8'd0) begin
              state  <= IDLE;
              rr_ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
            end else begin
              count <= count - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TBLINK_RPC_PKT_ARB_STATS_EN
  always_ff @(posedge uclock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
      last_src  <= '0;
    end else if (done) begin
      pkt_count <= pkt_count + 16'd1;
      last_src  <= gnt_idx;
    end
  end
`endif

endmodule

// File: tb/tb_tblink_rpc_pkt_arb.sv
// tb_tblink_rpc_pkt_arb: directed bench with a packet-level arbitration model.
// Build with TBLINK_RPC_PKT_ARB_STATS_EN to also cover pkt_count/last_src.
module tb_tblink_rpc_pkt_arb;
  localparam int N = 4;

  logic uclock  = 1'b0;
  logic reset_n = 1'b0;
  logic hreq_i  = 1'b0;
  logic hreq_o;

  tblink_rpc_pkt_arb_if #(.N_PORTS(N)) bus ();

`ifdef TBLINK_RPC_PKT_ARB_STATS_EN
  logic [15:0] pkt_count;
  logic [1:0]  last_src;
`endif

  tblink_rpc_pkt_arb #(.N_PORTS(N)) dut (
    .uclock (uclock),
    .reset_n(reset_n),
    .hreq_i (hreq_i),
    .hreq_o (hreq_o),
    .bus    (bus)
`ifdef TBLINK_RPC_PKT_ARB_STATS_EN
    ,
    .pkt_count(pkt_count),
    .last_src (last_src)
`endif
  );

  always #5 uclock = ~uclock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] srcq [N][$];
  logic [N-1:0] hold = '0;

  // Packet-level model: owner, bytes moved, total length once known.
  int m_own  = -1;
  int m_rr   = 0;
  int m_idx  = 0;
  int m_len  = 0;
  int m_pkts = 0;
  int m_last = 0;

  logic [7:0] log_b [$];
  int log_p [$];
  int own_q [$];
  int st_c  [$];
  int end_c [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus.req_valid[k] = (srcq[k].size() > 0) && !hold[k];
      bus.req_dat[8*k +: 8] = (srcq[k].size() > 0) ? srcq[k][0] : 8'h00;
    end
  endtask

  task automatic model_cycle();
    logic busy;
    logic [1:0] o;
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic ev;
    busy = (m_own >= 0);
    o  = busy ? 2'(m_own) : 2'd0;
    eg = busy ? (N'(1) << o) : '0;
    ev = busy ? bus.req_valid[o] : 1'b0;
    er = (busy && bus.out_ready) ? (N'(1) << o) : '0;
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("hreq_o", 32'(hreq_o), 32'(hreq_i | busy));
    if (ev) chk("out_dat", 32'(bus.out_dat), 32'(srcq[o][0]));
`ifdef TBLINK_RPC_PKT_ARB_STATS_EN
    chk("pkt_count", 32'(pkt_count), 32'(m_pkts % 65536));
    chk("last_src", 32'(last_src), 32'(m_last));
`endif
    if (busy) begin
      if (ev && bus.out_ready) begin
        log_b.push_back(srcq[o][0]);
        log_p.push_back(int'(o));
        if (m_idx == 0) st_c.push_back(cyc);
        if (m_idx == 1) m_len = int'(srcq[o][0]) + 3;
        m_idx++;
        if (m_idx == m_len) begin
          own_q.push_back(int'(o));
          end_c.push_back(cyc);
          m_rr = (int'(o) + 1) % N;
          m_own = -1;
          m_pkts++;
          m_last = int'(o);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_own < 0 && bus.req_valid[(m_rr + i) % N]) begin
          m_own = (m_rr + i) % N;
          m_idx = 0;
          m_len = 0;
        end
      end
    end
    for (int k = 0; k < N; k++)
      if (bus.req_valid[k] && bus.req_ready[k]) void'(srcq[k].pop_front());
  endtask

  task automatic step();
    drive();
    @(negedge uclock);
    model_cycle();
    @(posedge uclock);
    #1;
    cyc++;
  endtask

  function automatic bit pending();
    bit p;
    p = (m_own >= 0);
    for (int k = 0; k < N; k++) if (srcq[k].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_idle(int maxc, string name);
    int n;
    n = 0;
    while (pending() && n < maxc) begin
      step();
      n++;
    end
    chk(name, 32'(n < maxc), 32'd1);
  endtask

  task automatic clr_log();
    log_b.delete();
    log_p.delete();
    own_q.delete();
    st_c.delete();
    end_c.delete();
  endtask

  task automatic push_pkt(int p, logic [7:0] hdr, logic [7:0] c,
                          logic [7:0] base);
    srcq[p].push_back(hdr);
    srcq[p].push_back(c);
    for (int i = 0; i <= int'(c); i++) srcq[p].push_back(8'(int'(base) + i));
  endtask

  task automatic do_reset();
    logic [7:0] d0;
    d0 = (srcq[0].size() > 0) ? srcq[0][0] : 8'h00;
    reset_n = 1'b0;
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_hreq_o", 32'(hreq_o), 32'(hreq_i));
    chk("rst_out_dat", 32'(bus.out_dat), 32'(d0));
    m_own = -1; m_rr = 0; m_idx = 0; m_len = 0;
    m_pkts = 0; m_last = 0;
    for (int k = 0; k < N; k++) srcq[k].delete();
    hold = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  logic [7:0] exp1 [5] = '{8'h05, 8'h02, 8'hA1, 8'hA2, 8'hA3};
  logic [7:0] exp4 [8] = '{8'h22, 8'h05, 8'h60, 8'h61,
                           8'h62, 8'h63, 8'h64, 8'h65};
  int t0;
  int n;

  initial begin
    bus.out_ready = 1'b1;
    bus.req_valid = '0;
    bus.req_dat   = '0;
    #2;
    do_reset();

    // Single packet from port 2
    clr_log();
    t0 = cyc;
    push_pkt(2, 8'h05, 8'h02, 8'hA1);
    run_idle(20, "t1_done");
    chk("t1_beats", 32'(log_b.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_b.size(); i++)
      chk("t1_byte", 32'(log_b[i]), 32'(exp1[i]));
    chk("t1_owner", 32'(own_q[0]), 32'd2);
    chk("t1_first", 32'(st_c[0]), 32'(t0 + 1));
    chk("t1_span", 32'(end_c[0] - st_c[0]), 32'd4);
    chk("t1_rr", 32'(m_rr), 32'd3);

    // Fairness: all ports, three C=0 packets each
    clr_log();
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < N; p++)
        push_pkt(p, 8'(p*16 + r), 8'h00, 8'(p*16 + r + 128));
    run_idle(200, "t2_done");
    chk("t2_pkts", 32'(own_q.size()), 32'd12);
    for (int i = 0; i < 12 && i < own_q.size(); i++)
      chk("t2_order", 32'(own_q[i]), 32'((3 + i) % 4));
    for (int i = 1; i < 12 && i < own_q.size(); i++)
      chk("t2_bubble", 32'(st_c[i] - end_c[i-1]), 32'd2);

    // Atomicity: others arrive while port 1 is in payload
    clr_log();
    push_pkt(1, 8'h11, 8'h03, 8'h40);
    for (int i = 0; i < 4; i++) step();
    chk("t3_mid_owner", 32'(m_own), 32'd1);
    push_pkt(0, 8'h30, 8'h00, 8'h50);
    push_pkt(2, 8'h32, 8'h00, 8'h52);
    push_pkt(3, 8'h33, 8'h00, 8'h53);
    run_idle(100, "t3_done");
    chk("t3_pkts", 32'(own_q.size()), 32'd4);
    chk("t3_o0", 32'(own_q[0]), 32'd1);
    chk("t3_o1", 32'(own_q[1]), 32'd2);
    chk("t3_o2", 32'(own_q[2]), 32'd3);
    chk("t3_o3", 32'(own_q[3]), 32'd0);

    // Backpressure plus a 3-cycle source stall mid-payload
    clr_log();
    hreq_i = 1'b1;
    push_pkt(1, 8'h22, 8'h05, 8'h60);
    n = 0;
    while (pending() && n < 100) begin
      bus.out_ready = (n % 2 == 0);
      hold[1] = (n >= 8 && n < 11);
      step();
      n++;
    end
    chk("t4_done", 32'(n < 100), 32'd1);
    bus.out_ready = 1'b1;
    hold = '0;
    hreq_i = 1'b0;
    chk("t4_beats", 32'(log_b.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_b.size(); i++) begin
      chk("t4_byte", 32'(log_b[i]), 32'(exp4[i]));
      chk("t4_src", 32'(log_p[i]), 32'd1);
    end

    // Maximum length packet
    clr_log();
    push_pkt(2, 8'h7F, 8'hFF, 8'h00);
    run_idle(400, "t5_done");
    chk("t5_beats", 32'(log_b.size()), 32'd258);
    chk("t5_first_pay", 32'(log_b[2]), 32'h00);
    chk("t5_last_pay", 32'(log_b[257]), 32'hFF);
    chk("t5_span", 32'(end_c[0] - st_c[0]), 32'd257);
    chk("t5_rr", 32'(m_rr), 32'd3);

    // Reset after payload byte 10 of a second long packet
    clr_log();
    push_pkt(3, 8'h01, 8'hFF, 8'h00);
    n = 0;
    while (m_idx < 12 && n < 40) begin
      step();
      n++;
    end
    chk("t5_mid_reach", 32'(n < 40), 32'd1);
    do_reset();
    clr_log();
    push_pkt(2, 8'h42, 8'h00, 8'h72);
    push_pkt(0, 8'h40, 8'h00, 8'h70);
    run_idle(50, "t5_after_done");
    chk("t5_after_o0", 32'(own_q[0]), 32'd0);
    chk("t5_after_o1", 32'(own_q[1]), 32'd2);

    // Packets from ports 1, 3, 1 after a fresh reset
    do_reset();
    clr_log();
    push_pkt(1, 8'h01, 8'h01, 8'h10);
    run_idle(30, "t6_a");
    push_pkt(3, 8'h03, 8'h00, 8'h20);
    run_idle(30, "t6_b");
    push_pkt(1, 8'h01, 8'h02, 8'h30);
    run_idle(30, "t6_c");
    chk("t6_pkts", 32'(own_q.size()), 32'd3);
    chk("t6_last_owner", 32'(own_q[2]), 32'd1);
`ifdef TBLINK_RPC_PKT_ARB_STATS_EN
    chk("t6_pkt_count", 32'(pkt_count), 32'd3);
    chk("t6_last_src", 32'(last_src), 32'd1);
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
